// File: rtl/q2_pkg.sv
// q2_pkg: shared state encoding, opcodes and address-select codes for the Q2 sequencer.
package q2_pkg;
    typedef enum logic [2:0] {
        ST_HALT    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DEREF   = 3'd2,
        ST_LOAD    = 3'd3,
        ST_EXEC    = 3'd4,
        ST_ALU     = 3'd5,
        ST_DEPOSIT = 3'd6
    } state_t;
    localparam logic [2:0] OP_LDA  = 3'd0;
    localparam logic [2:0] OP_NOR  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SHR  = 3'd3;
    localparam logic [2:0] OP_LEA  = 3'd4;
    localparam logic [2:0] OP_STA  = 3'd5;
    localparam logic [2:0] OP_JMP  = 3'd6;
    localparam logic [2:0] OP_JMPF = 3'd7;
    localparam logic [1:0] ADDR_P     = 2'd0;
    localparam logic [1:0] ADDR_X     = 2'd1;
    localparam logic [1:0] ADDR_PANEL = 2'd2;
endpackage

// File: rtl/q2_bit_counter.sv
// q2_bit_counter: bit-serial cycle counter, wraps to zero after the terminal count WORD_WIDTH-1.
module q2_bit_counter #(
    parameter int WORD_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(WORD_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_en,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic                 o_tc
);
    logic [CNT_WIDTH-1:0] r_cnt;
    assign o_cnt = r_cnt;
    assign o_tc  = r_cnt == CNT_WIDTH'(WORD_WIDTH - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr || (i_en && o_tc))
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
endmodule

// File: rtl/q2_sequencer.sv
// q2_sequencer: Q2 CPU control sequencer; fetch/deref/load/exec/bit-serial ALU over a req/ack memory bus
// with front-panel run/step/deposit control.
module q2_sequencer
    import q2_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(WORD_WIDTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic       dep_sw,
    input  logic [2:0] opcode,
    input  logic       deref,
    input  logic       flag,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] addr_sel,
    output logic       ir_load,
    output logic       p_inc,
    output logic       p_load,
    output logic       x_load,
    output logic       a_write,
    output logic       f_write,
    output logic       alu_shift,
    output logic       alu_first,
    output logic       halted,
    output logic [2:0] state_o
);
    state_t               r_state;
    logic                 r_step_pending;
    logic                 r_mem_req;
    logic                 r_mem_we;
    logic [1:0]           r_addr_sel;
    logic                 r_dep_inc;
    logic                 r_p_load;
    logic                 r_a_write;
    logic                 r_f_write;
    logic                 r_alu_shift;
    logic                 r_alu_first;
    state_t               w_next;
    state_t               w_done;
    logic                 w_acc;
    logic                 w_sta;
    logic                 w_to_exec;
    logic                 w_to_alu;
    logic                 w_alu_last;
    logic                 w_in_alu;
    logic [CNT_WIDTH-1:0] w_cnt;
    logic                 w_tc;

    q2_bit_counter #(.WORD_WIDTH(WORD_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (!w_in_alu),
        .i_en  (w_in_alu),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    // An ack only counts while a request is actually outstanding.
    assign w_acc    = r_mem_req && mem_ack;
    assign w_sta    = opcode == OP_STA;
    assign w_in_alu = r_state == ST_ALU;

    always_comb begin
        w_done = (run && !r_step_pending) ? ST_FETCH : ST_HALT;
        w_next = ST_HALT;
        case (r_state)
            ST_HALT:    w_next = dep_sw ? ST_DEPOSIT : (step || run) ? ST_FETCH : ST_HALT;
            ST_DEPOSIT: w_next = w_acc ? ST_HALT : ST_DEPOSIT;
            ST_FETCH:   w_next = !w_acc ? ST_FETCH : deref ? ST_DEREF : opcode[2] ? ST_EXEC : ST_LOAD;
            ST_DEREF:   w_next = !w_acc ? ST_DEREF : opcode[2] ? ST_EXEC : ST_LOAD;
            ST_LOAD:    w_next = !w_acc ? ST_LOAD : (opcode == OP_LDA) ? ST_EXEC : ST_ALU;
            ST_EXEC:    w_next = (w_sta && !w_acc) ? ST_EXEC : w_done;
            ST_ALU:     w_next = w_tc ? w_done : ST_ALU;
            default:    w_next = ST_HALT;
        endcase
        w_to_exec  = w_next == ST_EXEC;
        w_to_alu   = w_next == ST_ALU;
        w_alu_last = w_in_alu && w_cnt == CNT_WIDTH'(WORD_WIDTH - 2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_HALT;
            r_step_pending <= 1'b0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_addr_sel     <= ADDR_P;
            r_dep_inc      <= 1'b0;
            r_p_load       <= 1'b0;
            r_a_write      <= 1'b0;
            r_f_write      <= 1'b0;
            r_alu_shift    <= 1'b0;
            r_alu_first    <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_step_pending <= (r_state == ST_HALT) ? (step && !dep_sw) : (r_step_pending && w_next != ST_HALT);
            r_mem_req      <= w_next == ST_FETCH || w_next == ST_DEREF || w_next == ST_LOAD ||
                              w_next == ST_DEPOSIT || (w_to_exec && w_sta);
            r_mem_we       <= w_next == ST_DEPOSIT || (w_to_exec && w_sta);
            r_addr_sel     <= (w_next == ST_DEPOSIT) ? ADDR_PANEL :
                              (w_next == ST_DEREF || w_next == ST_LOAD || w_to_exec) ? ADDR_X : ADDR_P;
            r_dep_inc      <= r_state == ST_DEPOSIT && w_acc;
            r_p_load       <= w_to_exec && (opcode == OP_JMP || (opcode == OP_JMPF && flag));
            r_a_write      <= (w_to_exec && (opcode == OP_LDA || opcode == OP_LEA)) || w_alu_last;
            r_f_write      <= w_alu_last && opcode != OP_NOR;
            r_alu_shift    <= w_to_alu;
            r_alu_first    <= w_to_alu && !w_in_alu;
        end
    end

    // Data-capture strobes coincide with the ack so the datapath latches memory data on that edge.
    assign ir_load   = r_state == ST_FETCH && w_acc;
    assign x_load    = (r_state == ST_DEREF || r_state == ST_LOAD) && w_acc;
    assign p_inc     = r_dep_inc || ir_load;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign addr_sel  = r_addr_sel;
    assign p_load    = r_p_load;
    assign a_write   = r_a_write;
    assign f_write   = r_f_write;
    assign alu_shift = r_alu_shift;
    assign alu_first = r_alu_first;
    assign halted    = r_state == ST_HALT;
    assign state_o   = r_state;
endmodule
